// File: rtl/aes_ctrl_pkg.sv
// Shared types and helpers for the AES stream job controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    // One 128-bit AES block is four 32-bit stream words.
    localparam int unsigned WORDS_PER_BLOCK = 4;

    // Word count for a job; callers keep the block count below 2**30.
    function automatic int unsigned total_words(input int unsigned nblocks);
        return nblocks * WORDS_PER_BLOCK;
    endfunction

endpackage

// File: rtl/aes_ctrl_hs_cnt.sv
// Handshake counter with limit compare; one instance per stream side.
// Latency: count updates the cycle after a fire; open/last are combinational on the count.
// Backpressure: none of its own; the parent gates fires with the open flag.
module aes_ctrl_hs_cnt #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         open,
    output logic         last
);

    logic [W-1:0] cnt;

    // Count accepted transfers; a clear wins over a simultaneous fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign open = (cnt != limit);
    assign last = (cnt == limit - W'(1));

endmodule

// File: rtl/aes_stream_ctrl.sv
// Job sequencer for stacker -> AES -> unstacker: clears, enables, gates 4*N words in, counts 4*N out.
// Latency: start sampled at edge k -> clear in cycle k+1 -> words accepted from cycle k+2; done 1 cycle after last output.
// Backpressure: pure combinational gating of valid/ready; source closed once the job's words are in.
// Optional perf counters built when AES_STREAM_CTRL_PERF_EN is defined, otherwise tied to zero.
module aes_stream_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int BLK_W  = 16,
    parameter int WORD_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             start_i,
    input  logic [BLK_W-1:0] nblocks_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             stk_clr_o,
    output logic             stk_enable_o,
    input  logic             src_valid_i,
    output logic             src_ready_o,
    output logic             stk_valid_o,
    input  logic             stk_ready_i,
    input  logic             unstk_valid_i,
    output logic             unstk_ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      perf_run_o,
    output logic [31:0]      perf_stall_o
);

    localparam int CNT_W = BLK_W + 2;

    // Word data bypasses this block; the width is carried for documentation of the stream.
    logic word_w_unused;
    assign word_w_unused = (WORD_W > 0);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] total_q;
    logic             load_total;
    logic             clear_state;
    logic             in_gate, out_gate;
    logic             in_open, in_last_unused;
    logic             out_open_unused, out_last;
    logic             in_fire, out_fire;
    logic             cnt_clr;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Job length latched when a non-empty job is accepted in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            total_q <= '0;
        end else if (load_total && !clr_i) begin
            total_q <= CNT_W'(total_words(32'(nblocks_i)));
        end
    end

    // Next-state and per-state gating; soft clear overrides everything.
    always_comb begin
        state_d     = state_q;
        load_total  = 1'b0;
        clear_state = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        stk_enable_o = 1'b0;
        in_gate     = 1'b0;
        out_gate    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (nblocks_i != '0) begin
                        load_total = 1'b1;
                        state_d    = ST_CLEAR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CLEAR: begin
                busy_o      = 1'b1;
                clear_state = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                busy_o       = 1'b1;
                stk_enable_o = 1'b1;
                in_gate      = in_open;
                out_gate     = 1'b1;
                if (out_fire && out_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr_i) begin
            state_d = ST_IDLE;
        end
    end

    assign stk_valid_o   = src_valid_i & in_gate;
    assign src_ready_o   = stk_ready_i & in_gate;
    assign out_valid_o   = unstk_valid_i & out_gate;
    assign unstk_ready_o = out_ready_i & out_gate;
    assign stk_clr_o     = clear_state | clr_i;

    assign in_fire  = stk_valid_o & stk_ready_i;
    assign out_fire = out_valid_o & out_ready_i;
    assign cnt_clr  = clr_i | clear_state;

    aes_ctrl_hs_cnt #(.W(CNT_W)) u_in_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (cnt_clr),
        .inc   (in_fire),
        .limit (total_q),
        .open  (in_open),
        .last  (in_last_unused)
    );

    aes_ctrl_hs_cnt #(.W(CNT_W)) u_out_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (cnt_clr),
        .inc   (out_fire),
        .limit (total_q),
        .open  (out_open_unused),
        .last  (out_last)
    );

`ifdef AES_STREAM_CTRL_PERF_EN
    logic [31:0] perf_run_q, perf_stall_q;

    // RUN-cycle and sink-stall counters; zeroed on job accept or soft clear, saturating, held after done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_run_q   <= '0;
            perf_stall_q <= '0;
        end else if (clr_i || load_total) begin
            perf_run_q   <= '0;
            perf_stall_q <= '0;
        end else if (state_q == ST_RUN) begin
            if (perf_run_q != '1) begin
                perf_run_q <= perf_run_q + 32'd1;
            end
            if (out_valid_o && !out_ready_i && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_run_o   = perf_run_q;
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_run_o   = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl with a behavioural stacker/AES/unstacker datapath and a job-level model.
// Latency: n/a.
// Backpressure: randomized source valid, stacker ready and sink ready.
module tb_aes_stream_ctrl;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_RUN   = 2;
    localparam int P_DONE  = 3;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        start;
    logic [15:0] nblocks;
    logic        busy, done, stk_clr, stk_en;
    logic        src_valid, src_ready, stk_valid, stk_ready;
    logic        unstk_valid, unstk_ready, out_valid, out_ready;
    logic [31:0] perf_run, perf_stall;

    aes_stream_ctrl #(.BLK_W(16), .WORD_W(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clr_i         (clr),
        .start_i       (start),
        .nblocks_i     (nblocks),
        .busy_o        (busy),
        .done_o        (done),
        .stk_clr_o     (stk_clr),
        .stk_enable_o  (stk_en),
        .src_valid_i   (src_valid),
        .src_ready_o   (src_ready),
        .stk_valid_o   (stk_valid),
        .stk_ready_i   (stk_ready),
        .unstk_valid_i (unstk_valid),
        .unstk_ready_o (unstk_ready),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .perf_run_o    (perf_run),
        .perf_stall_o  (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: actual %0h, required %0h", name, cyc, act, exp);
    endtask

    // Job-level model state.
    int     ph = P_IDLE;
    int     m_total = 0, m_in = 0, m_out = 0;
    longint m_run = 0, m_stall = 0;
    // Behavioural datapath: words in the stacker, a block in the AES register, words in the unstacker.
    int     stack_cnt = 0, out_avail = 0;
    bit     aes_full = 0;
    // Tallies of what the DUT actually did.
    int     in_hs_tot = 0, out_hs_tot = 0, done_tot = 0, clrout_tot = 0, en_tot = 0;
    int     last_done_cyc = -1, last_clr_cyc = -1;

    // Stimulus knobs.
    int     src_on = 0;     // 0 none, 1 random, 2 always
    int     sink_mode = 1;  // 0 random, 1 always ready, 2 never ready

    // Compare process: DUT outputs against the model every cycle, then advance the model.
    always @(negedge clk) begin
        bit         run, e_open, e_sv, e_sr, e_ov, e_ur, e_busy, e_done, e_clr, e_en;
        bit         in_fire, out_fire;
        logic [7:0] exp_v, act_v;
        logic [63:0] exp_p;
        act_v = {busy, done, stk_clr, stk_en, stk_valid, src_ready, out_valid, unstk_ready};
        if (!rst_n) begin
            chk("reset_outputs", {56'd0, act_v}, 64'd0);
            chk("reset_perf", {perf_run, perf_stall}, 64'd0);
            ph = P_IDLE; m_total = 0; m_in = 0; m_out = 0; m_run = 0; m_stall = 0;
            stack_cnt = 0; out_avail = 0; aes_full = 0;
        end else begin
            run    = (ph == P_RUN);
            e_open = (m_in < m_total);
            e_sv   = run && src_valid && e_open;
            e_sr   = run && stk_ready && e_open;
            e_ov   = run && unstk_valid;
            e_ur   = run && out_ready;
            e_busy = (ph == P_CLEAR) || run;
            e_done = (ph == P_DONE);
            e_clr  = (ph == P_CLEAR) || clr;
            e_en   = run;
            exp_v  = {e_busy, e_done, e_clr, e_en, e_sv, e_sr, e_ov, e_ur};
            chk("outputs", {56'd0, act_v}, {56'd0, exp_v});
`ifdef AES_STREAM_CTRL_PERF_EN
            exp_p = {m_run[31:0], m_stall[31:0]};
`else
            exp_p = 64'd0;
`endif
            chk("perf", {perf_run, perf_stall}, exp_p);

            if (stk_valid && stk_ready) in_hs_tot++;
            if (out_valid && out_ready) out_hs_tot++;
            if (done) begin done_tot++; last_done_cyc = cyc; end
            if (stk_clr) begin clrout_tot++; last_clr_cyc = cyc; end
            if (stk_en) en_tot++;

            in_fire  = e_sv && stk_ready;
            out_fire = e_ov && out_ready;

            // Perf: restart on abort or job accept, otherwise accumulate RUN / stalled-RUN cycles.
            if (clr || (ph == P_IDLE && start && nblocks != 0)) begin
                m_run = 0; m_stall = 0;
            end else if (run) begin
                if (m_run < 64'hFFFF_FFFF) m_run++;
                if (e_ov && !out_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
            end

            if (clr) begin
                ph = P_IDLE; m_in = 0; m_out = 0;
            end else begin
                case (ph)
                    P_IDLE: if (start) begin
                        if (nblocks != 0) begin ph = P_CLEAR; m_total = 4 * int'(nblocks); end
                        else ph = P_DONE;
                    end
                    P_CLEAR: begin m_in = 0; m_out = 0; ph = P_RUN; end
                    P_RUN: begin
                        m_in  += int'(in_fire);
                        m_out += int'(out_fire);
                        if (m_out == m_total) ph = P_DONE;
                    end
                    default: ph = P_IDLE;
                endcase
            end

            if (e_clr) begin
                stack_cnt = 0; out_avail = 0; aes_full = 0;
            end else begin
                if (out_fire) out_avail--;
                if (aes_full) begin out_avail += 4; aes_full = 0; end
                if (in_fire) begin
                    stack_cnt++;
                    if (stack_cnt == 4) begin stack_cnt = 0; aes_full = 1; end
                end
            end
        end
    end

    // Advance one cycle and drive the randomized handshake inputs shortly after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        src_valid   = (src_on == 2) || (src_on == 1 && ($urandom % 4) != 0);
        stk_ready   = !aes_full && (($urandom % 5) != 0);
        unstk_valid = (out_avail > 0);
        out_ready   = (sink_mode == 1) || (sink_mode == 0 && ($urandom % 3) != 0);
    endtask

    int start_cyc;

    task automatic start_job(input int nb);
        start   = 1'b1;
        nblocks = 16'(nb);
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int base_done, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_tot > base_done) break;
            tick();
        end
    endtask

    int bi, bo, bd, bc, be, clr_cyc;

    task automatic snap();
        bi = in_hs_tot; bo = out_hs_tot; bd = done_tot; bc = clrout_tot; be = en_tot;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; start = 1'b0; nblocks = '0;
        src_valid = 1'b0; stk_ready = 1'b0; unstk_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Two blocks, sink always ready.
        src_on = 1; sink_mode = 1; snap();
        start_job(2);
        wait_done(bd, 2000);
        chk("A_words_in", in_hs_tot - bi, 8);
        chk("A_words_out", out_hs_tot - bo, 8);
        chk("A_done_once", done_tot - bd, 1);
        chk("A_clear_cycle", last_clr_cyc, start_cyc + 1);
        tick();
        chk("A_busy_after", busy, 0);

        // One block, source always offering: only four words taken.
        src_on = 2; sink_mode = 1; snap();
        start_job(1);
        wait_done(bd, 2000);
        chk("B_words_in", in_hs_tot - bi, 4);
        chk("B_done_once", done_tot - bd, 1);
        tick();
        chk("B_src_closed", src_ready, 0);

        // Sink stalls ten cycles mid-job.
        src_on = 1; sink_mode = 1; snap();
        start_job(2);
        for (int i = 0; i < 2000 && (out_hs_tot - bo) < 2; i++) tick();
        sink_mode = 2; out_ready = 1'b0;
        repeat (10) tick();
        sink_mode = 1;
        wait_done(bd, 2000);
        chk("C_words_out", out_hs_tot - bo, 8);
        chk("C_done_once", done_tot - bd, 1);
`ifdef AES_STREAM_CTRL_PERF_EN
        chk("C_stall_ge10", perf_stall >= 32'd10, 1);
`else
        chk("C_perf_tied", {perf_run, perf_stall}, 64'd0);
`endif

        // Empty job: straight to done, no clear or enable.
        snap();
        start_job(0);
        tick(); tick();
        chk("D_done_once", done_tot - bd, 1);
        chk("D_done_cycle", last_done_cyc, start_cyc + 1);
        chk("D_no_clear", clrout_tot - bc, 0);
        chk("D_no_enable", en_tot - be, 0);

        // Abort after three words, then a fresh one-block job.
        src_on = 1; sink_mode = 1; snap();
        start_job(2);
        for (int i = 0; i < 2000 && (in_hs_tot - bi) < 3; i++) tick();
        src_on = 0; src_valid = 1'b0; clr = 1'b1; clr_cyc = cyc;
        tick();
        clr = 1'b0;
        chk("E_idle_after_clr", {busy, stk_en}, 0);
        tick(); tick();
        chk("E_words_in", in_hs_tot - bi, 3);
        chk("E_no_done", done_tot - bd, 0);
        chk("E_clr_seen", last_clr_cyc, clr_cyc);
        src_on = 1; snap();
        start_job(1);
        wait_done(bd, 2000);
        chk("E2_words_out", out_hs_tot - bo, 4);
        chk("E2_done_once", done_tot - bd, 1);

        // Start held high through the job.
        src_on = 1; sink_mode = 0; snap();
        start = 1'b1; nblocks = 16'd2;
        wait_done(bd, 2000);
        start = 1'b0;
        tick(); tick();
        chk("F_words_in", in_hs_tot - bi, 8);
        chk("F_done_once", done_tot - bd, 1);
        chk("F_one_clear", clrout_tot - bc, 1);

        // Asynchronous reset mid-job.
        snap();
        start_job(3);
        for (int i = 0; i < 2000 && (in_hs_tot - bi) < 5; i++) tick();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("G_idle_after_reset", {busy, done}, 0);

        // Random jobs, occasionally aborted.
        for (int j = 0; j < 20; j++) begin
            int nb;
            nb = int'($urandom_range(1, 6));
            src_on = 1; sink_mode = 0; snap();
            start_job(nb);
            if (($urandom % 4) == 0) begin
                repeat ($urandom_range(3, 20)) tick();
                clr = 1'b1;
                tick();
                clr = 1'b0;
                tick();
            end else begin
                wait_done(bd, 4000);
                chk("R_words_out", out_hs_tot - bo, 4 * nb);
                chk("R_done_once", done_tot - bd, 1);
            end
            repeat (2) tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
